// File: rtl/operand_entry_pkg.sv
// Shared types and defaults for the operand-entry front end of the
// min/max comparator display.
package operand_entry_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SHOW   = 2'd2
    } entry_state_e;

    // 10 ms hold time at a 50 MHz system clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage : operand_entry_pkg

// File: rtl/operand_entry_key_debounce.sv
// Per-key 2-flop synchroniser, hold-time debouncer and press pulse
// generator. The key is active-low, so a press is a stable 1->0 edge.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = operand_entry_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic             stable_d;

    // Synchroniser: idles high so a released key looks released out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: a new level must persist for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (sync_p1 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync_p1;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Press pulse: one cycle after the stable level falls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_d <= 1'b1;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end

endmodule : key_debounce

// File: rtl/operand_entry.sv
// Operand-entry front end: synchronises the switches, debounces the load
// and mode keys, and sequences operand capture for the comparator stage.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int W               = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    input  logic         key_load_n,
    input  logic         key_mode_n,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         c,
    output logic         ready,
    output logic [1:0]   stage
);

    logic [W-1:0] sw_p0;
    logic [W-1:0] sw_s;
    logic         load_press;
    logic         mode_press;
    entry_state_e state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_p0 <= '0;
            sw_s  <= '0;
        end else begin
            sw_p0 <= sw;
            sw_s  <= sw_p0;
        end
    end

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_key (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_load_n),
        .press(load_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_key (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_mode_n),
        .press(mode_press)
    );

    // Entry sequencer; mode toggling is independent of the load sequence
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD_A;
            a     <= '0;
            b     <= '0;
            c     <= 1'b0;
            ready <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (load_press) begin
                        a     <= sw_s;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (load_press) begin
                        b     <= sw_s;
                        ready <= 1'b1;
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (load_press) begin
                        a     <= sw_s;
                        ready <= 1'b0;
                        state <= LOAD_B;
                    end
                end
                default: begin
                    ready <= 1'b0;
                    state <= LOAD_A;
                end
            endcase
            if (mode_press) begin
                c <= ~c;
            end
        end
    end

    assign stage = state;

endmodule : operand_entry

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry with a short debounce window.
module tb_operand_entry;

    localparam int D = 4;
    localparam int W = 4;
    // Drive happens one edge before edge k; outputs move at edge k+3+D
    localparam int LAT = D + 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw = '0;
    logic         key_load_n = 1'b1;
    logic         key_mode_n = 1'b1;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         ready;
    logic [1:0]   stage;

    operand_entry #(
        .DEBOUNCE_CYCLES(D),
        .W              (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .key_load_n(key_load_n),
        .key_mode_n(key_mode_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .ready     (ready),
        .stage     (stage)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic       ready;
        logic [1:0] stage;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;
    logic armed = 1'b0;
    logic [11:0] cur;
    logic [11:0] prev;
    exp_t em;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every visible output change must match the next expected update
    always @(negedge clk) begin
        if (!mon_en) begin
            armed = 1'b0;
        end else begin
            cur = {a, b, c, ready, stage};
            if (!armed) begin
                prev  = cur;
                armed = 1'b1;
            end else if (cur !== prev) begin
                prev = cur;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_change actual=%h required=no_change (cycle %0d)", cur, cyc);
                end else begin
                    em = q.pop_front();
                    chk("upd_cycle", cyc, em.cyc);
                    chk("upd_a", int'(a), int'(em.a));
                    chk("upd_b", int'(b), int'(em.b));
                    chk("upd_c", int'(c), int'(em.c));
                    chk("upd_ready", int'(ready), int'(em.ready));
                    chk("upd_stage", int'(stage), int'(em.stage));
                end
            end
        end
    end

    task automatic push_exp(input logic [3:0] ea, eb, input logic ec, er,
                            input logic [1:0] es);
        exp_t e;
        e.cyc = cyc + LAT;
        e.a = ea; e.b = eb; e.c = ec; e.ready = er; e.stage = es;
        q.push_back(e);
    endtask

    task automatic press(input logic ld, md, input logic [3:0] swv,
                         input logic [3:0] ea, eb, input logic ec, er,
                         input logic [1:0] es);
        sw = swv;
        repeat (4) @(posedge clk);
        #1;
        push_exp(ea, eb, ec, er, es);
        if (ld) key_load_n = 1'b0;
        if (md) key_mode_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        key_load_n = 1'b1;
        key_mode_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] ea, eb,
                                 input logic ec, er, input logic [1:0] es);
        chk({tag, "_a"}, int'(a), int'(ea));
        chk({tag, "_b"}, int'(b), int'(eb));
        chk({tag, "_c"}, int'(c), int'(ec));
        chk({tag, "_ready"}, int'(ready), int'(er));
        chk({tag, "_stage"}, int'(stage), int'(es));
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Load A then B
        press(1'b1, 1'b0, 4'h9, 4'h9, 4'h0, 1'b0, 1'b0, 2'd1);
        press(1'b1, 1'b0, 4'h3, 4'h9, 4'h3, 1'b0, 1'b1, 2'd2);

        // Bounce rejection
        sw = 4'h7;
        for (int i = 0; i < 7; i++) begin
            key_load_n = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            key_load_n = 1'b1;
            @(posedge clk);
            #1;
        end
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("bounce_a", int'(a), 9);
        chk("bounce_b", int'(b), 3);
        chk("bounce_stage", int'(stage), 2);
        @(posedge clk);
        #1;

        // Mode toggles: 1, 0, 1, then back to 0
        press(1'b0, 1'b1, 4'h7, 4'h9, 4'h3, 1'b1, 1'b1, 2'd2);
        press(1'b0, 1'b1, 4'h7, 4'h9, 4'h3, 1'b0, 1'b1, 2'd2);
        press(1'b0, 1'b1, 4'h7, 4'h9, 4'h3, 1'b1, 1'b1, 2'd2);
        press(1'b0, 1'b1, 4'h7, 4'h9, 4'h3, 1'b0, 1'b1, 2'd2);

        // Reload from SHOW with simultaneous mode press
        press(1'b1, 1'b1, 4'hE, 4'hE, 4'h3, 1'b1, 1'b0, 2'd1);

        // Reset in the middle of a debounce count
        sw = 4'h5;
        repeat (4) @(posedge clk);
        #1;
        key_load_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(4'h5, 4'h0, 1'b0, 1'b0, 2'd1);
        @(negedge clk);
        check_outputs("midrst", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
        mon_en = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        #1;
        key_load_n = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_updates actual=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_operand_entry
